// File: rtl/noise_tester_pkg.sv
// Shared definitions for the noise-tester blocks: FSM encoding and default widths.
package noise_tester_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int WIN_W_DEF = 16;
   localparam int ERR_W_DEF = 16;

   // Sampling-clock period in system clocks; used by benches to pace strobes.
   localparam int SAMPLE_PERIOD_CLK = 252;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/bit_error_counter.sv
// Counts sampled bits and XOR-detected bit errors over a programmable window,
// reporting the totals with a one-cycle done pulse.
module bit_error_counter
   import noise_tester_pkg::*;
#(
   parameter int WIN_W = WIN_W_DEF,
   parameter int ERR_W = ERR_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_clk,
   input  logic             xor_in,
   input  logic             start,
   input  logic [WIN_W-1:0] window_len,
   output logic             busy,
   output logic             done,
   output logic [WIN_W-1:0] bit_count,
   output logic [ERR_W-1:0] err_count,
   output logic             err_sat
);

   logic             xor_s;
   logic             sc_d;
   logic             strobe;
   state_t           state;
   logic [WIN_W-1:0] len_q;
   logic [WIN_W-1:0] bit_next;
   logic [ERR_W-1:0] err_next;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   sync_2ff u_xor_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (xor_in),
      .q     (xor_s)
   );

   // sample_clk is generated in this clock domain, so one register suffices for edge detect.
   assign strobe   = sample_clk & ~sc_d;
   assign bit_next = bit_count + WIN_W'(1);
   assign err_next = sat_inc(err_count);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_d      <= 1'b0;
         state     <= ST_IDLE;
         len_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bit_count <= '0;
         err_count <= '0;
         err_sat   <= 1'b0;
      end else begin
         sc_d <= sample_clk;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  len_q     <= window_len;
                  bit_count <= '0;
                  err_count <= '0;
                  err_sat   <= 1'b0;
                  if (window_len == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_ARM;
                     busy  <= 1'b1;
                  end
               end
            end
            // Strobes during the accept and ARM cycles are deliberately dropped.
            ST_ARM: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (strobe) begin
                  bit_count <= bit_next;
                  if (xor_s) begin
                     err_count <= err_next;
                     if (&err_next)
                        err_sat <= 1'b1;
                  end
                  if (bit_next == len_q) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
